// File: rtl/mdu_ctrl_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// mdu_ctrl_pkg: shared op encoding, FSM states and op-class helpers for the MDU
// Rev 1.0
//------------------------------------------------------------------------------
package mdu_ctrl_pkg;

  localparam int MDU_XLEN  = 64;
  localparam int MDU_CNT_W = $clog2(MDU_XLEN);

  typedef enum logic [3:0] {
    MUL    = 4'd0,
    MULH   = 4'd1,
    MULHSU = 4'd2,
    MULHU  = 4'd3,
    DIV    = 4'd4,
    DIVU   = 4'd5,
    REM    = 4'd6,
    REMU   = 4'd7,
    MULW   = 4'd8,
    DIVW   = 4'd9,
    DIVUW  = 4'd10,
    REMW   = 4'd11,
    REMUW  = 4'd12
  } mdu_op_t;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } mdu_state_t;

  function automatic logic is_div(input mdu_op_t op);
    return op inside {DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW};
  endfunction

  function automatic logic is_rem(input mdu_op_t op);
    return op inside {REM, REMU, REMW, REMUW};
  endfunction

  // Both operands signed; MULHSU is handled separately since only rs1 is signed
  function automatic logic is_signed(input mdu_op_t op);
    return op inside {MULH, DIV, REM, DIVW, REMW};
  endfunction

  function automatic logic is_word(input mdu_op_t op);
    return op inside {MULW, DIVW, DIVUW, REMW, REMUW};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mdu_ctrl_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// mdu_ctrl_if: execute-side request and memory-side result handshake of the MDU
// Rev 1.0
//------------------------------------------------------------------------------
interface mdu_ctrl_if
  import mdu_ctrl_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
) ();

  logic            in_valid;
  logic            in_ready;
  mdu_op_t         in_op;
  logic [XLEN-1:0] in_a;
  logic [XLEN-1:0] in_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_result;
  logic            busy;

  modport master (
    output in_valid, in_op, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_result, busy
  );

  modport slave (
    input  in_valid, in_op, in_a, in_b, out_ready,
    output in_ready, out_valid, out_result, busy
  );

endinterface
`default_nettype wire

// File: rtl/mdu_iter.sv
`default_nettype none
//------------------------------------------------------------------------------
// mdu_iter: one shift-add multiply or restoring-divide step on magnitudes
// Rev 1.0
//------------------------------------------------------------------------------
module mdu_iter #(
  parameter int XLEN = 64
) (
  input  logic              is_div_i,
  input  logic [2*XLEN-1:0] acc_i,
  input  logic [XLEN-1:0]   sh_i,
  input  logic [XLEN-1:0]   opnd_i,
  output logic [2*XLEN-1:0] acc_o,
  output logic [XLEN-1:0]   sh_o
);

  logic [XLEN:0] trial;
  logic          qbit;

  // Both loops consume sh_i MSB-first, so W ops pre-shift operands into the top half
  always_comb begin
    trial = {acc_i[XLEN-1:0], sh_i[XLEN-1]};
    qbit  = (trial >= {1'b0, opnd_i});
    if (is_div_i) begin
      acc_o = {{XLEN{1'b0}}, (qbit ? (trial[XLEN-1:0] - opnd_i) : trial[XLEN-1:0])};
      sh_o  = {sh_i[XLEN-2:0], qbit};
    end else begin
      acc_o = (acc_i << 1) + (sh_i[XLEN-1] ? {{XLEN{1'b0}}, opnd_i} : {(2*XLEN){1'b0}});
      sh_o  = sh_i << 1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/mdu_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// mdu_ctrl: iterative RV64M mul/div sequencer; MDU_FASTPATH_EN skips CALC for trivial ops
// Rev 1.0
//------------------------------------------------------------------------------
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int XLEN = MDU_XLEN
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      flush,
  mdu_ctrl_if.slave bus
);

  localparam int CNT_W = $clog2(XLEN);
  localparam int HALF  = XLEN / 2;

  mdu_state_t        state_q;
  mdu_op_t           op_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [2*XLEN-1:0] acc_q, acc_d;
  logic [XLEN-1:0]   sh_q, sh_d, opnd_q, aext_q, result_q;
  logic              negq_q, negr_q, dz_q, ovf_q;
  logic              in_ready_q, out_valid_q, busy_q;

  logic              in_word, in_div, in_sa, in_sb, neg_a, neg_b, in_dz, in_ovf;
  logic [XLEN-1:0]   a_ext, b_ext, abs_a, abs_b, min_v, sh_init;
  logic              op_div, last;

  always_comb begin
    in_word = is_word(bus.in_op);
    in_div  = is_div(bus.in_op);
    in_sb   = is_signed(bus.in_op);
    in_sa   = in_sb || (bus.in_op == MULHSU);
    a_ext   = bus.in_a;
    b_ext   = bus.in_b;
    if (in_word) begin
      a_ext = {{HALF{in_sa & bus.in_a[HALF-1]}}, bus.in_a[HALF-1:0]};
      b_ext = {{HALF{in_sb & bus.in_b[HALF-1]}}, bus.in_b[HALF-1:0]};
    end
    neg_a   = in_sa & a_ext[XLEN-1];
    neg_b   = in_sb & b_ext[XLEN-1];
    abs_a   = neg_a ? -a_ext : a_ext;
    abs_b   = neg_b ? -b_ext : b_ext;
    min_v   = in_word ? {{(HALF+1){1'b1}}, {(HALF-1){1'b0}}} : {1'b1, {(XLEN-1){1'b0}}};
    in_dz   = in_div && (b_ext == '0);
    in_ovf  = in_div && in_sb && (a_ext == min_v) && (b_ext == '1);
    sh_init = in_div ? abs_a : abs_b;
    if (in_word) sh_init = sh_init << HALF;
  end

  assign op_div = is_div(op_q);
  assign last   = (cnt_q == (is_word(op_q) ? CNT_W'(HALF-1) : CNT_W'(XLEN-1)));

  mdu_iter #(.XLEN(XLEN)) u_iter (
    .is_div_i (op_div),
    .acc_i    (acc_q),
    .sh_i     (sh_q),
    .opnd_i   (opnd_q),
    .acc_o    (acc_d),
    .sh_o     (sh_d)
  );

  // Division by zero and signed overflow override the iterated magnitudes
  function automatic logic [XLEN-1:0] finish_result(
    input mdu_op_t           op,
    input logic [2*XLEN-1:0] acc,
    input logic [XLEN-1:0]   quo,
    input logic              negq,
    input logic              negr,
    input logic              dz,
    input logic              ovf,
    input logic [XLEN-1:0]   dvd
  );
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   res;
    prod = negq ? -acc : acc;
    res  = prod[XLEN-1:0];
    if (is_div(op)) begin
      if (dz)               res = is_rem(op) ? dvd : '1;
      else if (ovf)         res = is_rem(op) ? '0 : dvd;
      else if (is_rem(op))  res = negr ? -acc[XLEN-1:0] : acc[XLEN-1:0];
      else                  res = negq ? -quo : quo;
    end else if (op inside {MULH, MULHSU, MULHU}) begin
      res = prod[2*XLEN-1:XLEN];
    end
    if (is_word(op)) res = {{HALF{res[HALF-1]}}, res[HALF-1:0]};
    return res;
  endfunction

`ifdef MDU_FASTPATH_EN
  logic in_fast;
  assign in_fast = in_dz || in_ovf || (!in_div && ((a_ext == '0) || (b_ext == '0)));
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      op_q        <= MUL;
      cnt_q       <= '0;
      acc_q       <= '0;
      sh_q        <= '0;
      opnd_q      <= '0;
      aext_q      <= '0;
      result_q    <= '0;
      negq_q      <= 1'b0;
      negr_q      <= 1'b0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else if (flush) begin
      state_q     <= S_IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (bus.in_valid) begin
            op_q       <= bus.in_op;
            cnt_q      <= '0;
            acc_q      <= '0;
            sh_q       <= sh_init;
            opnd_q     <= in_div ? abs_b : abs_a;
            aext_q     <= a_ext;
            negq_q     <= neg_a ^ neg_b;
            negr_q     <= neg_a;
            dz_q       <= in_dz;
            ovf_q      <= in_ovf;
            in_ready_q <= 1'b0;
            busy_q     <= 1'b1;
`ifdef MDU_FASTPATH_EN
            if (in_fast) begin
              state_q     <= S_DONE;
              out_valid_q <= 1'b1;
              result_q    <= finish_result(bus.in_op, '0, '0, 1'b0, 1'b0, in_dz, in_ovf, a_ext);
            end else begin
              state_q <= S_CALC;
            end
`else
            state_q <= S_CALC;
`endif
          end
        end
        S_CALC: begin
          acc_q <= acc_d;
          sh_q  <= sh_d;
          cnt_q <= cnt_q + CNT_W'(1);
          if (last) begin
            state_q     <= S_DONE;
            out_valid_q <= 1'b1;
            result_q    <= finish_result(op_q, acc_d, sh_d, negq_q, negr_q, dz_q, ovf_q, aext_q);
          end
        end
        S_DONE: begin
          if (bus.out_ready) begin
            state_q     <= S_IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
          end
        end
        default: begin
          state_q     <= S_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_result = result_q;
  assign bus.busy       = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_mdu_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_mdu_ctrl: directed self-checking bench for the MDU sequencer
// Rev 1.0
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_mdu_ctrl;
  import mdu_ctrl_pkg::*;

  localparam int XLEN = 64;
`ifdef MDU_FASTPATH_EN
  localparam int FAST = 1;
`else
  localparam int FAST = 0;
`endif

  typedef struct {
    mdu_op_t     op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic flush = 1'b0;
  int   errors = 0;
  int   checks = 0;
  vec_t vt[4];

  mdu_ctrl_if #(.XLEN(XLEN)) bus ();

  mdu_ctrl #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .reset (reset),
    .flush (flush),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic start_op(input mdu_op_t op, input logic [63:0] a, input logic [63:0] b,
                          output logic busy1);
    bus.in_valid = 1'b1;
    bus.in_op    = op;
    bus.in_a     = a;
    bus.in_b     = b;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    bus.in_op    = MULHU;
    bus.in_a     = 64'hDEAD_BEEF_0BAD_F00D;
    bus.in_b     = 64'h0123_4567_89AB_CDEF;
    busy1        = bus.busy;
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic take(output logic [63:0] res);
    res = bus.out_result;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic run_op(input mdu_op_t op, input logic [63:0] a, input logic [63:0] b,
                        output logic [63:0] res, output int lat, output logic busy1);
    start_op(op, a, b, busy1);
    wait_valid(lat);
    take(res);
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.out_result !== 64'h0) begin errors++; $display("FAIL reset_out_result: got %h expected 0", bus.out_result); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", bus.busy); end
    reset = 1'b0;
  endtask

  task automatic test_mul();
    logic [63:0] res; int lat; logic b1;
    vt[0] = '{MUL,    64'd7,                  -64'sd3, 64'hFFFF_FFFF_FFFF_FFEB, 65};
    vt[1] = '{MULHU,  64'hFFFF_FFFF_FFFF_FFFF, 64'd2,  64'h1,                  65};
    vt[2] = '{MULHSU, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2,  64'hFFFF_FFFF_FFFF_FFFF, 65};
    vt[3] = '{MULH,   64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, 65};
    for (int i = 0; i < 4; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, res, lat, b1);
      checks++; if (res !== vt[i].exp) begin errors++; $display("FAIL mul[%0d] result: got %h expected %h", i, res, vt[i].exp); end
      checks++; if (lat !== vt[i].lat) begin errors++; $display("FAIL mul[%0d] latency: got %0d expected %0d", i, lat, vt[i].lat); end
      checks++; if (b1 !== 1'b1) begin errors++; $display("FAIL mul[%0d] busy_T+1: got %b expected 1", i, b1); end
    end
  endtask

  task automatic test_div();
    logic [63:0] res; int lat; logic b1;
    vt[0] = '{DIV,  -64'sd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 65};
    vt[1] = '{REM,  -64'sd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 65};
    vt[2] = '{DIVU, 64'd20,   64'd3, 64'd6,                   65};
    vt[3] = '{REMU, 64'd20,   64'd3, 64'd2,                   65};
    for (int i = 0; i < 4; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, res, lat, b1);
      checks++; if (res !== vt[i].exp) begin errors++; $display("FAIL div[%0d] result: got %h expected %h", i, res, vt[i].exp); end
      checks++; if (lat !== vt[i].lat) begin errors++; $display("FAIL div[%0d] latency: got %0d expected %0d", i, lat, vt[i].lat); end
    end
  endtask

  task automatic test_divzero();
    logic [63:0] res; int lat; logic b1;
    int l = (FAST != 0) ? 1 : 65;
    vt[0] = '{DIV,  64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, l};
    vt[1] = '{REMU, 64'd5, 64'd0, 64'd5,                   l};
    vt[2] = '{DIV,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000, l};
    vt[3] = '{REM,  64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, l};
    for (int i = 0; i < 4; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, res, lat, b1);
      checks++; if (res !== vt[i].exp) begin errors++; $display("FAIL special[%0d] result: got %h expected %h", i, res, vt[i].exp); end
      checks++; if (lat !== vt[i].lat) begin errors++; $display("FAIL special[%0d] latency: got %0d expected %0d", i, lat, vt[i].lat); end
    end
  endtask

  task automatic test_word();
    logic [63:0] res; int lat; logic b1;
    vt[0] = '{DIVW,  64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_8000_0000, (FAST != 0) ? 1 : 33};
    vt[1] = '{MULW,  64'h0000_0000_0001_0000, 64'h0000_0000_0001_0000, 64'h0, 33};
    vt[2] = '{REMW,  64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 33};
    vt[3] = '{DIVUW, 64'h0000_0000_FFFF_FFFF, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 33};
    for (int i = 0; i < 4; i++) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, res, lat, b1);
      checks++; if (res !== vt[i].exp) begin errors++; $display("FAIL word[%0d] result: got %h expected %h", i, res, vt[i].exp); end
      checks++; if (lat !== vt[i].lat) begin errors++; $display("FAIL word[%0d] latency: got %0d expected %0d", i, lat, vt[i].lat); end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] res; int lat; logic b1;
    start_op(DIVU, 64'd20, 64'd3, b1);
    wait_valid(lat);
    checks++; if (lat !== 65) begin errors++; $display("FAIL hold_latency: got %0d expected 65", lat); end
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_result !== 64'd6 || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold[%0d]: got valid=%b result=%h in_ready=%b expected 1/6/0", i, bus.out_valid, bus.out_result, bus.in_ready);
      end
    end
    take(res);
    checks++; if (res !== 64'd6) begin errors++; $display("FAIL hold_result: got %h expected 6", res); end
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL after_handoff: got valid=%b in_ready=%b busy=%b expected 0/1/0", bus.out_valid, bus.in_ready, bus.busy);
    end
    run_op(MUL, 64'd3, 64'd4, res, lat, b1);
    checks++; if (res !== 64'd12) begin errors++; $display("FAIL next_op: got %h expected c", res); end
  endtask

  task automatic test_flush();
    logic b1; logic seen;
    start_op(MUL, 64'd7, -64'sd3, b1);
    repeat (10) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL flush_calc: got busy=%b in_ready=%b valid=%b expected 0/1/0", bus.busy, bus.in_ready, bus.out_valid);
    end
    seen = 1'b0;
    repeat (80) begin @(posedge clk); #1; if (bus.out_valid !== 1'b0) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_no_valid: got %b expected 0", seen); end
  endtask

  task automatic test_reset_mid();
    logic b1; logic seen;
    start_op(DIVU, 64'd100, 64'd7, b1);
    repeat (20) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL rst_mid_in_ready: got %b expected 1", bus.in_ready); end
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_out_valid: got %b expected 0", bus.out_valid); end
    checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL rst_mid_busy: got %b expected 0", bus.busy); end
    checks++; if (bus.out_result !== 64'h0) begin errors++; $display("FAIL rst_mid_result: got %h expected 0", bus.out_result); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    seen = 1'b0;
    repeat (80) begin @(posedge clk); #1; if (bus.out_valid !== 1'b0) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rst_mid_no_valid: got %b expected 0", seen); end
  endtask

  task automatic test_flush_idle();
    logic [63:0] res; int lat; logic b1; logic seen;
    bus.in_valid = 1'b1;
    bus.in_op    = DIV;
    bus.in_a     = 64'd9;
    bus.in_b     = 64'd3;
    flush        = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    flush        = 1'b0;
    checks++;
    if (bus.busy !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_idle: got busy=%b in_ready=%b expected 0/1", bus.busy, bus.in_ready);
    end
    seen = 1'b0;
    repeat (70) begin @(posedge clk); #1; if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0) seen = 1'b1; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL flush_idle_quiet: got %b expected 0", seen); end
    run_op(DIV, 64'd9, 64'd3, res, lat, b1);
    checks++; if (res !== 64'd3) begin errors++; $display("FAIL after_flush_op: got %h expected 3", res); end
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_op     = MUL;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_mul();
    test_div();
    test_divzero();
    test_word();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    test_flush_idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
- Sequencer for an iterative multiply/divide unit beside the combinational ALU in the execute stage.
- Accepts one RV64M operation from execute and runs a shift-add multiplier or a restoring divider, one bit per cycle.
- Drives `busy` so the hazard logic stalls decode/execute.
- Returns a sign-corrected result through a valid/ready handshake toward memory.

Parameters:
- XLEN, 64, operand/result width. Must be even; the W ops use XLEN/2.

Ports:
- clk  input  1  pipeline clock
- reset  input  1  asynchronous, active-high reset
- flush  input  1  kill the in-flight op (branch mispredict/exception)
- in_valid  input  1  execute presents an MDU op
- in_ready  output  1  controller can accept an op
- in_op  input  4  mdu_op_t: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU, MULW, DIVW, DIVUW, REMW, REMUW
- in_a  input  XLEN  rs1 value
- in_b  input  XLEN  rs2 value
- out_valid  output  1  result available
- out_ready  input  1  downstream takes the result
- out_result  output  XLEN  final result
- busy  output  1  state != IDLE; drives the pipeline stall

Behaviour:
- Reset values:
  - state = IDLE; in_ready = 1; out_valid = 0; out_result = 0; busy = 0.
  - All internal registers and the counter = 0.
- States: IDLE, CALC, DONE.
- IDLE:
  - in_ready = 1.
  - Acceptance happens on in_valid && in_ready && !flush.
  - On acceptance, latch op, operand signs and absolute values (W ops: low 32 bits, sign/zero-extended per op); counter = 0; go to CALC.
- CALC:
  - One iteration per cycle.
  - N = XLEN for full-width ops, XLEN/2 for W ops.
  - When counter == N-1, the next state is DONE.
  - Multiplication keeps a 2*XLEN product register. MULH* return the upper half; MUL returns the lower half.
- DONE:
  - out_valid = 1. out_result is registered and stable while out_valid && !out_ready.
  - On out_ready, go to IDLE.
- Latency: acceptance in cycle T -> out_valid first high in cycle T+N+1.
- Back-to-back: in_ready is high only in IDLE, so there is at least one bubble between ops.
- Sign correction (applied on the DONE transition):
  - Quotient negated if the signs differ (signed ops).
  - Remainder takes the sign of the dividend.
  - MULHSU treats only `a` as signed.
- W ops: the 32-bit result is sign-extended to XLEN (this includes DIVUW/REMUW).
- Divide by zero:
  - Quotient = all ones (W: 0xFFFFFFFF sign-extended).
  - Remainder = dividend.
  - Still takes the full N cycles unless MDU_FASTPATH_EN is defined.
- Signed overflow (DIV/REM with a = most-negative, b = -1; W: on 32 bits):
  - Quotient = dividend, remainder = 0.
- flush:
  - Highest priority. From any state, next state = IDLE and out_valid drops next cycle.
  - If flush coincides with in_valid in IDLE, the op is not accepted.
  - If flush coincides with out_ready in DONE, the result is discarded (no double hand-off).
- reset mid-operation: immediate return to reset values; no output is produced.
- in_a, in_b and in_op are ignored outside the acceptance cycle.

Optional Feature:
- Macro: MDU_FASTPATH_EN.
- Defined:
  - Acceptance goes straight to DONE in cycle T+1 (out_valid at T+1) when any of these hold:
    - divisor == 0,
    - the op is a multiply and either operand == 0,
    - signed overflow.
  - The special-case result rules apply.
- Undefined: every op takes N CALC cycles; results are identical.

Decomposition:
- Shared package (common): mdu_op_t enum; is_div, is_signed and is_word helper functions; MDU_CNT_W = $clog2(XLEN).
- Sub-module mdu_iter: a pure datapath step that computes the next product/remainder/quotient from the current registers and op class.
- mdu_ctrl holds the FSM, counter, operand latch, sign correction and handshake.

Test Plan:
- MUL a=7, b=-3 (XLEN=64) -> out_result 0xFFFFFFFFFFFFFFEB, out_valid at T+65, busy high from T+1 until hand-off.
- DIV a=-20, b=3 -> out_result -6; REM, same operands -> -2; DIVU a=20, b=3 -> 6.
- DIV a=5, b=0 -> 0xFFFFFFFFFFFFFFFF; REMU, same operands -> 5; DIV a=0x8000000000000000, b=-1 -> 0x8000000000000000. With MDU_FASTPATH_EN: out_valid at T+1.
- DIVW a=0x00000000_80000000, b=0xFFFFFFFF_FFFFFFFF -> 0xFFFFFFFF80000000, out_valid at T+33; MULW a=0x10000, b=0x10000 -> 0.
- Hold out_ready low 5 cycles in DONE -> out_valid and out_result stable, in_ready low. Raise out_ready -> IDLE next cycle, then accept a new op.
- Assert flush at counter 10 -> IDLE next cycle, no out_valid. Assert reset at counter 20 -> all outputs at reset values immediately. flush && in_valid in IDLE -> op not accepted, busy stays 0.
